// File: rtl/cpu_types_pkg.sv
// Shared types and encodings for the MIPS pipeline memory stage.
package cpu_types_pkg;

    localparam int PKG_WORD_W   = 32;
    localparam int PKG_REGSEL_W = 5;

    typedef logic [PKG_WORD_W-1:0]   word_t;
    typedef logic [PKG_REGSEL_W-1:0] regbits_t;

    // memToReg: which value the write-back stage selects for the register file
    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_LUI = 2'd2;
    localparam logic [1:0] MTR_PC4 = 2'd3;

    // regDest: which instruction field names the destination register
    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } mem_state_t;

    // True when an entry is a real instruction that touches data memory
    function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
        return valid & (rd | wr);
    endfunction

endpackage

// File: rtl/memory_access_fsm.sv
// Data-cache access sequencer: holds one request on the bus until dhit,
// then parks in DONE until the pipeline advances. Also owns the load-hold
// register so load data survives a stalled write-back.
module memory_access_fsm
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = PKG_WORD_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              load_mem,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload_cache,
    output logic              dren,
    output logic              dwen,
    output logic              mem_stall,
    output logic [WORD_W-1:0] dmemload
);

    mem_state_t        state_r;
    mem_state_t        state_next_s;
    logic [WORD_W-1:0] hold_r;
    logic              hit_s;

    // Only a dhit while a request is on the bus completes an access
    assign hit_s = (state_r == ACCESS) & dhit;

    // State register; reset drops any outstanding request immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: an advance always restarts from the incoming entry
    always_comb begin
        state_next_s = state_r;
        if (advance) begin
            if (load_mem) begin
                state_next_s = ACCESS;
            end else begin
                state_next_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE:    state_next_s = IDLE;
                ACCESS:  state_next_s = dhit ? DONE : ACCESS;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Bus request and stall; a read wins if both control bits are ever set
    always_comb begin
        dren      = 1'b0;
        dwen      = 1'b0;
        mem_stall = 1'b0;
        if (state_r == ACCESS) begin
            dren      = mem_read;
            dwen      = mem_write & ~mem_read;
            mem_stall = ~dhit;
        end else begin
            dren      = 1'b0;
            dwen      = 1'b0;
            mem_stall = 1'b0;
        end
    end

    // Capture load data on the completing dhit; kept through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= {WORD_W{1'b0}};
        end else if (hit_s) begin
            hold_r <= dmemload_cache;
        end
    end

    // Live data on the hit cycle lets dhit and advance coincide
    assign dmemload = hit_s ? dmemload_cache : hold_r;

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, data-cache
// request generation, stall/advance control and MEM/WB output fields.
module memory_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = PKG_WORD_W,
    parameter int REGSEL_W = PKG_REGSEL_W
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic [WORD_W-1:0]   dmemload_cache,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic                ex_memRead,
    input  logic                ex_memWrite,
    input  logic [1:0]          ex_regDest,
    input  logic [1:0]          ex_memToReg,
    input  logic                ex_regWr,
    input  logic                ex_halt,
    input  logic [REGSEL_W-1:0] ex_wsel,
    input  logic [WORD_W-1:0]   ex_portO,
    input  logic [WORD_W-1:0]   ex_storeData,
    input  logic [WORD_W-1:0]   ex_luiValue,
    input  logic [WORD_W-1:0]   ex_pc4,
    output logic                dREN,
    output logic                dWEN,
    output logic [WORD_W-1:0]   daddr,
    output logic [WORD_W-1:0]   dstore,
    output logic                mem_stall,
    output logic                advance,
    output logic [1:0]          regDest_out,
    output logic [1:0]          memToReg_out,
    output logic                regWr_out,
    output logic [REGSEL_W-1:0] wsel_out,
    output logic                halt_out,
    output logic [WORD_W-1:0]   dmemload_out,
    output logic [WORD_W-1:0]   portO_out,
    output logic [WORD_W-1:0]   luiValue_out,
    output logic [WORD_W-1:0]   pc4_out
);

    // EX/MEM pipeline register fields
    logic                valid_r;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [1:0]          reg_dest_r;
    logic [1:0]          mem_to_reg_r;
    logic                reg_wr_r;
    logic                halt_r;
    logic [REGSEL_W-1:0] wsel_r;
    logic [WORD_W-1:0]   port_o_r;
    logic [WORD_W-1:0]   store_data_r;
    logic [WORD_W-1:0]   lui_value_r;
    logic [WORD_W-1:0]   pc4_r;
    logic                sticky_halt_r;

    logic in_valid_s;
    logic load_mem_s;
    logic advance_s;
    logic mem_stall_s;

    assign in_valid_s = ex_valid & ~flush;
    assign load_mem_s = is_mem_op(in_valid_s, ex_memRead, ex_memWrite);

    // Once halted the pipeline freezes; nothing advances while in reset
    assign advance_s = ihit & ~mem_stall_s & ~sticky_halt_r & ~RST;

    // EX/MEM register; squashed entries carry no control side effects
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_r      <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            reg_dest_r   <= 2'b00;
            mem_to_reg_r <= 2'b00;
            reg_wr_r     <= 1'b0;
            halt_r       <= 1'b0;
            wsel_r       <= {REGSEL_W{1'b0}};
            port_o_r     <= {WORD_W{1'b0}};
            store_data_r <= {WORD_W{1'b0}};
            lui_value_r  <= {WORD_W{1'b0}};
            pc4_r        <= {WORD_W{1'b0}};
        end else if (advance_s) begin
            valid_r      <= in_valid_s;
            mem_read_r   <= in_valid_s & ex_memRead;
            mem_write_r  <= in_valid_s & ex_memWrite;
            reg_dest_r   <= in_valid_s ? ex_regDest  : 2'b00;
            mem_to_reg_r <= in_valid_s ? ex_memToReg : 2'b00;
            reg_wr_r     <= in_valid_s & ex_regWr;
            halt_r       <= in_valid_s & ex_halt;
            wsel_r       <= ex_wsel;
            port_o_r     <= ex_portO;
            store_data_r <= ex_storeData;
            lui_value_r  <= ex_luiValue;
            pc4_r        <= ex_pc4;
        end
    end

    // Sticky halt: set by a loaded halt, only reset clears it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sticky_halt_r <= 1'b0;
        end else if (advance_s & in_valid_s & ex_halt) begin
            sticky_halt_r <= 1'b1;
        end
    end

    memory_access_fsm #(
        .WORD_W (WORD_W)
    ) u_fsm (
        .clk            (CLK),
        .rst            (RST),
        .advance        (advance_s),
        .load_mem       (load_mem_s),
        .mem_read       (valid_r & mem_read_r),
        .mem_write      (valid_r & mem_write_r),
        .dhit           (dhit),
        .dmemload_cache (dmemload_cache),
        .dren           (dREN),
        .dwen           (dWEN),
        .mem_stall      (mem_stall_s),
        .dmemload       (dmemload_out)
    );

    assign mem_stall    = mem_stall_s;
    assign advance      = advance_s;
    assign daddr        = port_o_r;
    assign dstore       = store_data_r;
    assign regDest_out  = reg_dest_r;
    assign memToReg_out = mem_to_reg_r;
    assign regWr_out    = reg_wr_r;
    assign wsel_out     = wsel_r;
    assign halt_out     = halt_r | sticky_halt_r;
    assign portO_out    = port_o_r;
    assign luiValue_out = lui_value_r;
    assign pc4_out      = pc4_r;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a scoreboard of expected MEM/WB entries.
module tb_memory_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, flush;
    logic [31:0] dmemload_cache;
    logic        ex_valid, ex_memRead, ex_memWrite, ex_regWr, ex_halt;
    logic [1:0]  ex_regDest, ex_memToReg;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_portO, ex_storeData, ex_luiValue, ex_pc4;
    logic        dREN, dWEN, mem_stall, advance, regWr_out, halt_out;
    logic [31:0] daddr, dstore, dmemload_out, portO_out, luiValue_out, pc4_out;
    logic [1:0]  regDest_out, memToReg_out;
    logic [4:0]  wsel_out;

    typedef struct {
        logic [31:0] port_o;
        logic [31:0] lui;
        logic [31:0] pc4;
        logic [4:0]  wsel;
        logic        reg_wr;
        logic        halt;
        logic [1:0]  mtr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    memory_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemload_cache(dmemload_cache), .flush(flush), .ex_valid(ex_valid),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_regDest(ex_regDest), .ex_memToReg(ex_memToReg),
        .ex_regWr(ex_regWr), .ex_halt(ex_halt), .ex_wsel(ex_wsel),
        .ex_portO(ex_portO), .ex_storeData(ex_storeData),
        .ex_luiValue(ex_luiValue), .ex_pc4(ex_pc4),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .mem_stall(mem_stall), .advance(advance),
        .regDest_out(regDest_out), .memToReg_out(memToReg_out),
        .regWr_out(regWr_out), .wsel_out(wsel_out), .halt_out(halt_out),
        .dmemload_out(dmemload_out), .portO_out(portO_out),
        .luiValue_out(luiValue_out), .pc4_out(pc4_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        assert (obs === expected) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expected);
        end
    endtask

    task automatic clear_ex();
        flush = 1'b0; ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
        ex_regDest = 2'b00; ex_memToReg = 2'b00; ex_regWr = 1'b0; ex_halt = 1'b0;
        ex_wsel = 5'd0; ex_portO = 32'd0; ex_storeData = 32'd0;
        ex_luiValue = 32'd0; ex_pc4 = 32'd0;
    endtask

    // Drive one execute-stage entry and record what MEM/WB should see for it
    task automatic drive_op(input logic v, input logic rd, input logic wr, input logic hlt,
                            input logic fl, input logic rw, input logic [4:0] ws,
                            input logic [31:0] po, input logic [31:0] sd, input logic [1:0] mtr);
        exp_t e;
        logic live;
        ex_valid = v; ex_memRead = rd; ex_memWrite = wr; ex_halt = hlt; flush = fl;
        ex_regWr = rw; ex_wsel = ws; ex_portO = po; ex_storeData = sd;
        ex_memToReg = mtr; ex_regDest = RDST_RD;
        ex_luiValue = {po[15:0], 16'h0000};
        ex_pc4 = po + 32'd4;
        live     = v & ~fl;
        e.port_o = po;
        e.lui    = {po[15:0], 16'h0000};
        e.pc4    = po + 32'd4;
        e.wsel   = ws;
        e.reg_wr = live & rw;
        e.halt   = live & hlt;
        e.mtr    = live ? mtr : 2'b00;
        sb.push_back(e);
    endtask

    // Pop the oldest expected entry and compare against the MEM/WB fields
    task automatic check_entry(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_portO"}, portO_out, e.port_o);
            chk({tag, "_lui"}, luiValue_out, e.lui);
            chk({tag, "_pc4"}, pc4_out, e.pc4);
            chk({tag, "_wsel"}, 32'(wsel_out), 32'(e.wsel));
            chk({tag, "_regWr"}, 32'(regWr_out), 32'(e.reg_wr));
            chk({tag, "_halt"}, 32'(halt_out), 32'(e.halt));
            chk({tag, "_memToReg"}, 32'(memToReg_out), 32'(e.mtr));
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; dmemload_cache = 32'd0;
        clear_ex();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_dREN", 32'(dREN), 32'd0);
        chk("rst_dWEN", 32'(dWEN), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_advance", 32'(advance), 32'd0);
        chk("rst_portO", portO_out, 32'd0);
        chk("rst_dmemload", dmemload_out, 32'd0);
        chk("rst_halt", 32'(halt_out), 32'd0);
        chk("rst_regWr", 32'(regWr_out), 32'd0);
        RST = 1'b0;
        @(negedge CLK); #1;
        chk("post_rst_portO", portO_out, 32'd0);
        chk("post_rst_dREN", 32'(dREN), 32'd0);

        // ALU op: visible the cycle after it is loaded, no bus activity
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA, 32'd0, MTR_ALU);
        ihit = 1'b1; #1;
        chk("alu_advance", 32'(advance), 32'd1);
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("alu");
        chk("alu_dREN", 32'(dREN), 32'd0);
        chk("alu_dWEN", 32'(dWEN), 32'd0);
        chk("alu_stall", 32'(mem_stall), 32'd0);

        // Load with a 3-cycle miss, then parked in DONE while ihit is low
        drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0100, 32'd0, MTR_MEM);
        ihit = 1'b1;
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("load");
        chk("load_c1_dREN", 32'(dREN), 32'd1);
        chk("load_c1_dWEN", 32'(dWEN), 32'd0);
        chk("load_c1_daddr", daddr, 32'h0000_0100);
        chk("load_c1_stall", 32'(mem_stall), 32'd1);
        @(negedge CLK); #1;
        chk("load_c2_dREN", 32'(dREN), 32'd1);
        chk("load_c2_stall", 32'(mem_stall), 32'd1);
        @(negedge CLK);
        dhit = 1'b1; dmemload_cache = 32'hDEAD_BEEF; #1;
        chk("load_c3_stall", 32'(mem_stall), 32'd0);
        chk("load_c3_data", dmemload_out, 32'hDEAD_BEEF);
        chk("load_c3_advance", 32'(advance), 32'd0);
        @(negedge CLK); dhit = 1'b0; dmemload_cache = 32'd0; #1;
        chk("load_done_dREN", 32'(dREN), 32'd0);
        chk("load_done_stall", 32'(mem_stall), 32'd0);
        chk("load_done_data", dmemload_out, 32'hDEAD_BEEF);
        chk("load_done_portO", portO_out, 32'h0000_0100);
        @(negedge CLK);
        dhit = 1'b1; dmemload_cache = 32'hCAFE_F00D; #1;
        chk("stray_done_data", dmemload_out, 32'hDEAD_BEEF);
        chk("stray_done_dREN", 32'(dREN), 32'd0);
        dhit = 1'b0; dmemload_cache = 32'd0;

        // Bubble advance, then a stray dhit in IDLE must not touch the hold data
        drive_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, MTR_ALU);
        ihit = 1'b1; #1;
        chk("bubble_advance", 32'(advance), 32'd1);
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("bubble");
        dhit = 1'b1; dmemload_cache = 32'hCAFE_F00D; #1;
        chk("stray_idle_data", dmemload_out, 32'hDEAD_BEEF);
        chk("stray_idle_stall", 32'(mem_stall), 32'd0);
        @(negedge CLK); dhit = 1'b0; dmemload_cache = 32'd0; #1;
        chk("stray_idle_kept", dmemload_out, 32'hDEAD_BEEF);

        // Store completing with dhit and ihit together: one dWEN cycle, no DONE
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0200, 32'h0000_1234, MTR_ALU);
        ihit = 1'b1;
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("store");
        chk("store_dWEN", 32'(dWEN), 32'd1);
        chk("store_dREN", 32'(dREN), 32'd0);
        chk("store_dstore", dstore, 32'h0000_1234);
        chk("store_daddr", daddr, 32'h0000_0200);
        chk("store_stall", 32'(mem_stall), 32'd1);
        drive_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0055, 32'd0, MTR_ALU);
        ihit = 1'b1; dhit = 1'b1; #1;
        chk("store_hit_stall", 32'(mem_stall), 32'd0);
        chk("store_hit_advance", 32'(advance), 32'd1);
        @(negedge CLK); ihit = 1'b0; dhit = 1'b0; clear_ex(); #1;
        check_entry("after_store");
        chk("after_store_dWEN", 32'(dWEN), 32'd0);
        chk("after_store_stall", 32'(mem_stall), 32'd0);
        @(negedge CLK); #1;
        chk("after_store_dWEN2", 32'(dWEN), 32'd0);

        // Flushed store: no register write, no bus write
        drive_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0300, 32'h0000_BEEF, MTR_ALU);
        ihit = 1'b1; #1;
        chk("flush_advance", 32'(advance), 32'd1);
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("flush");
        chk("flush_dWEN", 32'(dWEN), 32'd0);
        chk("flush_stall", 32'(mem_stall), 32'd0);
        @(negedge CLK); #1;
        chk("flush_dWEN2", 32'(dWEN), 32'd0);

        // Reset in the middle of an access drops the request at once
        drive_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0400, 32'd0, MTR_MEM);
        ihit = 1'b1;
        @(negedge CLK); ihit = 1'b0; clear_ex(); #1;
        check_entry("load2");
        chk("load2_dREN", 32'(dREN), 32'd1);
        #1 RST = 1'b1; #1;
        chk("midrst_dREN", 32'(dREN), 32'd0);
        chk("midrst_dWEN", 32'(dWEN), 32'd0);
        chk("midrst_stall", 32'(mem_stall), 32'd0);
        chk("midrst_portO", portO_out, 32'd0);
        chk("midrst_wsel", 32'(wsel_out), 32'd0);
        chk("midrst_regWr", 32'(regWr_out), 32'd0);
        chk("midrst_dmemload", dmemload_out, 32'd0);
        @(negedge CLK); RST = 1'b0; #1;
        chk("postrst_dREN", 32'(dREN), 32'd0);
        chk("postrst_stall", 32'(mem_stall), 32'd0);
        @(negedge CLK); #1;
        chk("postrst_idle_dREN", 32'(dREN), 32'd0);

        // Halt: sticky, freezes the pipeline even with ihit, cleared by reset
        drive_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0600, 32'd0, MTR_ALU);
        ihit = 1'b1; #1;
        chk("halt_advance_in", 32'(advance), 32'd1);
        @(negedge CLK);
        clear_ex(); ex_valid = 1'b1; ex_regWr = 1'b1; ex_portO = 32'h0000_0777; #1;
        check_entry("halt");
        chk("halt_freeze_advance", 32'(advance), 32'd0);
        repeat (3) @(negedge CLK);
        #1;
        chk("halt_sticky", 32'(halt_out), 32'd1);
        chk("halt_frozen_portO", portO_out, 32'h0000_0600);
        chk("halt_frozen_advance", 32'(advance), 32'd0);
        RST = 1'b1; #1;
        chk("halt_rst_halt", 32'(halt_out), 32'd0);
        chk("halt_rst_advance", 32'(advance), 32'd0);
        @(negedge CLK); RST = 1'b0; clear_ex(); #1;
        chk("halt_cleared", 32'(halt_out), 32'd0);
        chk("halt_cleared_advance", 32'(advance), 32'd1);
        ihit = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
